// File: rtl/or1k_arb_pkg.sv
// Shared types and constants for the OR1K ibus/dbus arbiter.
package or1k_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IBUS = 2'd1,
    ST_DBUS = 2'd2
  } arb_state_t;

  typedef enum logic {
    M_IBUS = 1'b0,
    M_DBUS = 1'b1
  } arb_master_t;

  localparam logic [3:0] OR1K_IBUS_BSEL = 4'hf;

endpackage

// File: rtl/or1k_arb_rr2.sv
// Stateless two-way round-robin pick: on a tie the master not granted last wins.
module or1k_arb_rr2
  import or1k_arb_pkg::*;
(
  input  logic        req_i,
  input  logic        req_d,
  input  arb_master_t last_grant,
  output logic        grant_valid,
  output arb_master_t grant
);

  always_comb begin
    grant_valid = req_i | req_d;
    grant       = M_IBUS;
    if (req_i && req_d)
      grant = (last_grant == M_IBUS) ? M_DBUS : M_IBUS;
    else if (req_d)
      grant = M_DBUS;
  end

endmodule

// File: rtl/or1k_bus_arbiter.sv
// Merges the OR1K ibus and dbus onto one memory port; grant is held for a
// full single or burst transaction and responses go only to the owner.
//
// state   | meaning
// IDLE    | no owner; arbitrate pending requests, responses ignored
// IBUS    | ibus owns the memory port
// DBUS    | dbus owns the memory port
module or1k_bus_arbiter
  import or1k_arb_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int BURST_LENGTH         = 8
) (
  input  logic                            clk,
  input  logic                            rst,

  input  logic                            ibus_req_i,
  input  logic                            ibus_burst_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] ibus_adr_i,
  output logic                            ibus_ack_o,
  output logic                            ibus_err_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] ibus_dat_o,

  input  logic                            dbus_req_i,
  input  logic                            dbus_we_i,
  input  logic                            dbus_burst_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] dbus_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] dbus_dat_i,
  input  logic [3:0]                      dbus_bsel_i,
  output logic                            dbus_ack_o,
  output logic                            dbus_err_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] dbus_dat_o,

  output logic                            mem_req_o,
  output logic                            mem_we_o,
  output logic                            mem_burst_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] mem_adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] mem_dat_o,
  output logic [3:0]                      mem_bsel_o,
  input  logic                            mem_ack_i,
  input  logic                            mem_err_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] mem_dat_i
);

  localparam int               CNT_W     = $clog2(BURST_LENGTH);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LENGTH - 1);

  arb_state_t       state;
  arb_master_t      last_grant;
  logic             burst_q;
  logic [CNT_W-1:0] beat_cnt;

  logic             win_valid;
  arb_master_t      win;
  logic             own_req;
  arb_master_t      own_master;
  logic             last_beat;
  logic             xfer_end;

  or1k_arb_rr2 u_rr2 (
    .req_i       (ibus_req_i),
    .req_d       (dbus_req_i),
    .last_grant  (last_grant),
    .grant_valid (win_valid),
    .grant       (win)
  );

  assign own_master = (state == ST_DBUS) ? M_DBUS : M_IBUS;
  assign own_req    = (state == ST_IBUS) ? ibus_req_i :
                      (state == ST_DBUS) ? dbus_req_i : 1'b0;
  assign last_beat  = (beat_cnt == LAST_BEAT);
  // Error wins over ack; a dropped request aborts without waiting for the slave.
  assign xfer_end   = mem_err_i || !own_req || (mem_ack_i && (!burst_q || last_beat));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      last_grant <= M_IBUS;
      burst_q    <= 1'b0;
      beat_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            state    <= (win == M_IBUS) ? ST_IBUS : ST_DBUS;
            burst_q  <= (win == M_IBUS) ? ibus_burst_i : dbus_burst_i;
            beat_cnt <= '0;
          end
        end
        default: begin
          if (xfer_end) begin
            state      <= ST_IDLE;
            last_grant <= own_master;
          end else if (mem_ack_i) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_burst_o = 1'b0;
    mem_adr_o   = '0;
    mem_dat_o   = '0;
    mem_bsel_o  = '0;
    ibus_ack_o  = 1'b0;
    ibus_err_o  = 1'b0;
    ibus_dat_o  = '0;
    dbus_ack_o  = 1'b0;
    dbus_err_o  = 1'b0;
    dbus_dat_o  = '0;
    case (state)
      ST_IBUS: begin
        mem_req_o   = ibus_req_i;
        mem_burst_o = burst_q && !last_beat;
        mem_adr_o   = ibus_adr_i;
        mem_bsel_o  = OR1K_IBUS_BSEL;
        ibus_ack_o  = mem_ack_i && !mem_err_i;
        ibus_err_o  = mem_err_i;
        ibus_dat_o  = mem_dat_i;
      end
      ST_DBUS: begin
        mem_req_o   = dbus_req_i;
        mem_we_o    = dbus_we_i;
        mem_burst_o = burst_q && !last_beat;
        mem_adr_o   = dbus_adr_i;
        mem_dat_o   = dbus_dat_i;
        mem_bsel_o  = dbus_bsel_i;
        dbus_ack_o  = mem_ack_i && !mem_err_i;
        dbus_err_o  = mem_err_i;
        dbus_dat_o  = mem_dat_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_or1k_bus_arbiter.sv
// Directed bench for or1k_bus_arbiter: grants, round-robin ties, bursts, errors, aborts, reset.
module tb_or1k_bus_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         ibus_req_i, ibus_burst_i;
  logic [W-1:0] ibus_adr_i;
  logic         ibus_ack_o, ibus_err_o;
  logic [W-1:0] ibus_dat_o;
  logic         dbus_req_i, dbus_we_i, dbus_burst_i;
  logic [W-1:0] dbus_adr_i, dbus_dat_i;
  logic [3:0]   dbus_bsel_i;
  logic         dbus_ack_o, dbus_err_o;
  logic [W-1:0] dbus_dat_o;
  logic         mem_req_o, mem_we_o, mem_burst_o;
  logic [W-1:0] mem_adr_o, mem_dat_o;
  logic [3:0]   mem_bsel_o;
  logic         mem_ack_i, mem_err_i;
  logic [W-1:0] mem_dat_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  or1k_bus_arbiter #(.OPTION_OPERAND_WIDTH(W), .BURST_LENGTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .ibus_req_i   (ibus_req_i),
    .ibus_burst_i (ibus_burst_i),
    .ibus_adr_i   (ibus_adr_i),
    .ibus_ack_o   (ibus_ack_o),
    .ibus_err_o   (ibus_err_o),
    .ibus_dat_o   (ibus_dat_o),
    .dbus_req_i   (dbus_req_i),
    .dbus_we_i    (dbus_we_i),
    .dbus_burst_i (dbus_burst_i),
    .dbus_adr_i   (dbus_adr_i),
    .dbus_dat_i   (dbus_dat_i),
    .dbus_bsel_i  (dbus_bsel_i),
    .dbus_ack_o   (dbus_ack_o),
    .dbus_err_o   (dbus_err_o),
    .dbus_dat_o   (dbus_dat_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_burst_o  (mem_burst_o),
    .mem_adr_o    (mem_adr_o),
    .mem_dat_o    (mem_dat_o),
    .mem_bsel_o   (mem_bsel_o),
    .mem_ack_i    (mem_ack_i),
    .mem_err_i    (mem_err_i),
    .mem_dat_i    (mem_dat_i)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    ibus_req_i = 0; ibus_burst_i = 0; ibus_adr_i = '0;
    dbus_req_i = 0; dbus_we_i = 0; dbus_burst_i = 0;
    dbus_adr_i = '0; dbus_dat_i = '0; dbus_bsel_i = '0;
    mem_ack_i = 0; mem_err_i = 0; mem_dat_i = '0;
    step(); step();
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_bsel", mem_bsel_o, 0);
    chk("rst_ibus_ack", ibus_ack_o, 0);
    rst = 1'b1;
    step();

    // lone ibus single read
    ibus_req_i = 1; ibus_adr_i = 32'h100;
    #2 chk("t1_latency", mem_req_o, 0);
    step();
    chk("t1_mem_req", mem_req_o, 1);
    chk("t1_mem_adr", mem_adr_o, 32'h100);
    chk("t1_mem_bsel", mem_bsel_o, 4'hf);
    chk("t1_mem_we", mem_we_o, 0);
    mem_ack_i = 1; mem_dat_i = 32'hDEADBEEF;
    #2;
    chk("t1_ibus_ack", ibus_ack_o, 1);
    chk("t1_ibus_dat", ibus_dat_o, 32'hDEADBEEF);
    chk("t1_dbus_ack", dbus_ack_o, 0);
    chk("t1_dbus_dat", dbus_dat_o, 0);
    step();
    mem_ack_i = 0; ibus_req_i = 0;
    #2 chk("t1_idle", mem_req_o, 0);

    // tie out of reset: dbus, then ibus, then dbus again
    rst = 0; step(); rst = 1;
    ibus_req_i = 1; dbus_req_i = 1; dbus_we_i = 1;
    dbus_adr_i = 32'h200; dbus_dat_i = 32'h55; dbus_bsel_i = 4'h3;
    step();
    chk("t2_first_adr", mem_adr_o, 32'h200);
    chk("t2_first_we", mem_we_o, 1);
    chk("t2_first_bsel", mem_bsel_o, 4'h3);
    chk("t2_first_dat", mem_dat_o, 32'h55);
    mem_ack_i = 1;
    #2 chk("t2_dbus_ack", dbus_ack_o, 1);
    chk("t2_ibus_ack", ibus_ack_o, 0);
    step(); mem_ack_i = 0;
    #2 chk("t2_bubble", mem_req_o, 0);
    step();
    chk("t2_second_adr", mem_adr_o, 32'h100);
    chk("t2_second_bsel", mem_bsel_o, 4'hf);
    mem_ack_i = 1;
    #2 chk("t2_second_ack", ibus_ack_o, 1);
    step(); mem_ack_i = 0;
    step();
    chk("t2_third_adr", mem_adr_o, 32'h200);
    mem_ack_i = 1;
    #2 chk("t2_third_ack", dbus_ack_o, 1);
    step(); mem_ack_i = 0; ibus_req_i = 0; dbus_req_i = 0;

    // dbus burst of 8
    step();
    dbus_req_i = 1; dbus_burst_i = 1; dbus_we_i = 0; dbus_adr_i = 32'h400;
    step();
    for (int b = 0; b < 8; b++) begin
      mem_ack_i = 1; mem_dat_i = 32'h1000 + b;
      #2;
      chk($sformatf("t3_ack_b%0d", b), dbus_ack_o, 1);
      chk($sformatf("t3_burst_b%0d", b), mem_burst_o, (b != 7) ? 1 : 0);
      chk($sformatf("t3_dat_b%0d", b), dbus_dat_o, 32'h1000 + b);
      step();
    end
    mem_ack_i = 0; dbus_req_i = 0; dbus_burst_i = 0;
    #2 chk("t3_idle", mem_req_o, 0);
    chk("t3_no_extra_ack", dbus_ack_o, 0);

    // ibus burst, error (with coincident ack) at beat 3; dbus waiting
    ibus_req_i = 1; ibus_burst_i = 1; ibus_adr_i = 32'h800;
    dbus_req_i = 1; dbus_adr_i = 32'h300; dbus_we_i = 1;
    step();
    chk("t4_owner", mem_adr_o, 32'h800);
    for (int b = 0; b < 3; b++) begin
      mem_ack_i = 1;
      #2 chk($sformatf("t4_ack_b%0d", b), ibus_ack_o, 1);
      step();
    end
    mem_ack_i = 1; mem_err_i = 1;
    #2;
    chk("t4_err", ibus_err_o, 1);
    chk("t4_err_no_ack", ibus_ack_o, 0);
    chk("t4_dbus_err", dbus_err_o, 0);
    step();
    mem_ack_i = 0; mem_err_i = 0; ibus_req_i = 0; ibus_burst_i = 0;
    #2 chk("t4_idle", mem_req_o, 0);
    chk("t4_err_gone", ibus_err_o, 0);
    step();
    chk("t4_dbus_grant", mem_adr_o, 32'h300);
    chk("t4_dbus_we", mem_we_o, 1);
    mem_ack_i = 1;
    step();
    mem_ack_i = 0; dbus_req_i = 0; dbus_we_i = 0;
    step();

    // abort: owner drops req at beat 2, then stray ack in IDLE
    ibus_req_i = 1; ibus_burst_i = 1;
    step();
    for (int b = 0; b < 2; b++) begin
      mem_ack_i = 1;
      step();
    end
    mem_ack_i = 0; ibus_req_i = 0;
    #2 chk("t5_req_falls", mem_req_o, 0);
    step();
    mem_ack_i = 1;
    #2;
    chk("t5_stray_ibus", ibus_ack_o, 0);
    chk("t5_stray_dbus", dbus_ack_o, 0);
    step();
    mem_ack_i = 0; ibus_burst_i = 0;

    // reset mid-burst, then a full burst shows the beat counter restarted
    dbus_req_i = 1; dbus_burst_i = 1; dbus_adr_i = 32'h500;
    step();
    for (int b = 0; b < 3; b++) begin
      mem_ack_i = 1;
      step();
    end
    chk("t6_pre_rst_req", mem_req_o, 1);
    rst = 0;
    #1;
    chk("t6_rst_req", mem_req_o, 0);
    chk("t6_rst_burst", mem_burst_o, 0);
    chk("t6_rst_adr", mem_adr_o, 0);
    chk("t6_rst_ack", dbus_ack_o, 0);
    mem_ack_i = 0;
    step();
    rst = 1;
    #2 chk("t6_idle_after", mem_req_o, 0);
    step();
    for (int b = 0; b < 8; b++) begin
      mem_ack_i = 1;
      #2 chk($sformatf("t6_burst_b%0d", b), mem_burst_o, (b != 7) ? 1 : 0);
      step();
    end
    mem_ack_i = 0; dbus_req_i = 0; dbus_burst_i = 0;
    #2 chk("t6_end_idle", mem_req_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
